// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, default rates and accumulator sizing
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    localparam int unsigned UART_DEFAULT_BAUD     = 115200;
    localparam int unsigned UART_DEFAULT_IN_CLOCK = 50000000;

    // Phase accumulator width: at least 29 bits, wider only if acc + increment could overflow.
    function automatic int unsigned uart_acc_width(input longint unsigned in_clock,
                                                   input longint unsigned inc);
        int unsigned need;
        need = unsigned'($clog2(in_clock + inc + 64'd1));
        if (need < 29) begin
            need = 29;
        end
        return need;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - fractional baud tick generator (phase accumulator)
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned BAUD     = UART_DEFAULT_BAUD,
    parameter int unsigned IN_CLOCK = UART_DEFAULT_IN_CLOCK,
    parameter int unsigned MULT     = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam longint unsigned INC_FULL = longint'(BAUD) * longint'(MULT);
    localparam longint unsigned CLK_FULL = longint'(IN_CLOCK);
    localparam int unsigned     ACC_W    = uart_acc_width(CLK_FULL, INC_FULL);
    localparam logic [ACC_W-1:0] INC_V   = INC_FULL[ACC_W-1:0];
    localparam logic [ACC_W-1:0] CLK_V   = CLK_FULL[ACC_W-1:0];

    if (INC_FULL > CLK_FULL) begin : g_rate_check
        $error("uart_baud_tick: BAUD*MULT exceeds IN_CLOCK");
    end

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    // Tick fires on any clk where the accumulated phase crosses IN_CLOCK.
    always_comb begin
        sum  = acc + INC_V;
        tick = (sum >= CLK_V);
    end

    // Accumulate the phase, wrapping by IN_CLOCK on each tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (tick) begin
            acc <= sum - CLK_V;
        end else begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled 8N1 UART receiver with byte strobe and framing error
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD       = UART_DEFAULT_BAUD,
    parameter int unsigned IN_CLOCK   = UART_DEFAULT_IN_CLOCK,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);

    if (OVERSAMPLE < 8 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_os_check
        $error("uart_rx: OVERSAMPLE must be a power of two and at least 8");
    end

    logic tick;

    uart_baud_tick #(
        .BAUD     (BAUD),
        .IN_CLOCK (IN_CLOCK),
        .MULT     (OVERSAMPLE)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    logic [1:0]       sync;
    logic             rxs;
    uart_rx_state_t   state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shift, shift_next;
    logic [7:0]       data_next;
    logic             valid_next, err_next;

    assign rxs  = sync[1];
    assign busy = (state != IDLE);

    // Two-flop synchroniser on the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    // Frame state, counters and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data       <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_next;
            shift      <= shift_next;
            data       <= data_next;
            data_valid <= valid_next;
            frame_err  <= err_next;
        end
    end

    // Next-state logic; everything advances only on sample ticks.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        data_next  = data;
        valid_next = 1'b0;
        err_next   = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_next = START;
                        cnt_next   = '0;
                    end
                end
                START: begin
                    if (cnt == MID_CNT) begin
                        if (!rxs) begin
                            cnt_next   = '0;
                            bit_next   = '0;
                            state_next = DATA;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt_next   = '0;
                        shift_next = {rxs, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state_next = STOP;
                        end else begin
                            bit_next = bit_idx + 3'd1;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt_next = '0;
                        if (rxs) begin
                            data_next  = shift;
                            valid_next = 1'b1;
                            state_next = IDLE;
                        end else begin
                            err_next   = 1'b1;
                            state_next = BREAK;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a behavioural line model
module tb_uart_rx;

    localparam int unsigned BAUD = 100000;
    localparam int unsigned INCK = 1600000;
    localparam int unsigned OS   = 16;
    localparam int          BITC = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx #(.BAUD(BAUD), .IN_CLOCK(INCK), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    logic [7:0] dv_q[$];
    int         dv_cyc[$];
    int         fe_cnt = 0;
    int         proto_viol = 0;
    logic       prev_dv = 1'b0;
    logic       prev_fe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe seen on the outputs, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (data_valid) begin
                dv_q.push_back(data);
                dv_cyc.push_back(cyc);
            end
            if (frame_err) fe_cnt++;
            if ((data_valid && frame_err) || (data_valid && prev_dv) || (frame_err && prev_fe))
                proto_viol++;
        end
        prev_dv = data_valid;
        prev_fe = frame_err;
    end

    task automatic clear_log();
        dv_q.delete();
        dv_cyc.delete();
        fe_cnt = 0;
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Ideal 8N1 transmitter: start, 8 bits LSB first, stop bit(s).
    task automatic send_byte(input logic [7:0] b, input int stop_bits, input logic stop_val);
        hold(1'b0, BITC);
        for (int i = 0; i < 8; i++) hold(b[i], BITC);
        hold(stop_val, BITC * stop_bits);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data actual=%h required=00", data); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv actual=%b required=0", data_valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_fe actual=%b required=0", frame_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b required=0", busy); end
        @(posedge clk); #1;
        reset = 1'b0;
        hold(1'b1, 8);
    endtask

    task automatic test_single();
        int fall;
        int lat;
        clear_log();
        fall = cyc;
        send_byte(8'hA5, 1, 1'b1);
        hold(1'b1, 3 * BITC);
        n_checks++; if (dv_q.size() != 1) begin n_fail++; $display("FAIL single_count actual=%0d required=1", dv_q.size()); end
        if (dv_q.size() >= 1) begin
            lat = dv_cyc[0] - fall;
            n_checks++; if (dv_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data actual=%h required=a5", dv_q[0]); end
            n_checks++; if (lat < 150 || lat > 158) begin n_fail++; $display("FAIL single_latency actual=%0d required=150..158", lat); end
        end
        n_checks++; if (fe_cnt != 0) begin n_fail++; $display("FAIL single_fe actual=%0d required=0", fe_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] fixed[4];
        logic [7:0] b;
        fixed = '{8'h00, 8'hFF, 8'h55, 8'h0D};
        clear_log();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(fixed[i]);
            send_byte(fixed[i], 1, 1'b1);
        end
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_byte(b, 1 + int'($urandom_range(1, 0)), 1'b1);
        end
        hold(1'b1, 3 * BITC);
        n_checks++; if (dv_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count actual=%0d required=%0d", dv_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < dv_q.size(); i++) begin
            n_checks++;
            if (dv_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_data[%0d] actual=%h required=%h", i, dv_q[i], exp_q[i]); end
        end
        n_checks++; if (fe_cnt != 0) begin n_fail++; $display("FAIL b2b_fe actual=%0d required=0", fe_cnt); end
    endtask

    task automatic test_glitch();
        int waited;
        clear_log();
        hold(1'b0, 5);
        rx = 1'b1;
        waited = 0;
        @(negedge clk);
        while (busy !== 1'b0 && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy actual=%b required=0 after %0d clk", busy, waited); end
        @(posedge clk); #1;
        hold(1'b1, 2 * BITC);
        n_checks++; if (dv_q.size() != 0 || fe_cnt != 0) begin n_fail++; $display("FAIL glitch_strobe actual=dv%0d/fe%0d required=0/0", dv_q.size(), fe_cnt); end
    endtask

    task automatic test_frame_err();
        logic [7:0] prior;
        prior = data;
        clear_log();
        send_byte(8'h3C, 1, 1'b0);
        hold(1'b0, 40);
        hold(1'b1, BITC);
        n_checks++; if (fe_cnt != 1) begin n_fail++; $display("FAIL ferr_count actual=%0d required=1", fe_cnt); end
        n_checks++; if (dv_q.size() != 0) begin n_fail++; $display("FAIL ferr_dv actual=%0d required=0", dv_q.size()); end
        n_checks++; if (data !== prior) begin n_fail++; $display("FAIL ferr_hold actual=%h required=%h", data, prior); end
        send_byte(8'h7E, 1, 1'b1);
        hold(1'b1, 2 * BITC);
        n_checks++; if (dv_q.size() != 1) begin n_fail++; $display("FAIL ferr_next_count actual=%0d required=1", dv_q.size()); end
        n_checks++; if (data !== 8'h7E) begin n_fail++; $display("FAIL ferr_next_data actual=%h required=7e", data); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h81;
        clear_log();
        hold(1'b0, BITC);
        for (int i = 0; i < 4; i++) hold(b[i], BITC);
        hold(b[4], BITC / 2);
        rx = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || data !== 8'h00) begin n_fail++; $display("FAIL midreset_state actual=busy%b/%h required=busy0/00", busy, data); end
        @(posedge clk); #1;
        reset = 1'b0;
        hold(1'b1, 2 * BITC);
        send_byte(8'h42, 1, 1'b1);
        hold(1'b1, 2 * BITC);
        n_checks++; if (dv_q.size() != 1) begin n_fail++; $display("FAIL midreset_count actual=%0d required=1", dv_q.size()); end
        if (dv_q.size() >= 1) begin
            n_checks++; if (dv_q[0] !== 8'h42) begin n_fail++; $display("FAIL midreset_data actual=%h required=42", dv_q[0]); end
        end
        n_checks++; if (fe_cnt != 0) begin n_fail++; $display("FAIL midreset_fe actual=%0d required=0", fe_cnt); end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (proto_viol != 0) begin n_fail++; $display("FAIL strobe_rules actual=%0d violations required=0", proto_viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
